// File: rtl/posit_ctrl_pkg.sv
// Shared types, constants and helpers for the posit add/subtract scheduler.
package posit_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } sched_state_t;

    localparam int NREQ    = 2;
    localparam int ID_W    = 1;
    localparam int POSIT_N = 32;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [POSIT_N-1:0] data;
    } res_entry_t;

    // Two's-complement negation; for a posit this is exact negation, and it
    // leaves zero and NaR unchanged. Callers keep the low N bits.
    function automatic logic [63:0] posit_neg(input logic [63:0] x);
        logic signed [63:0] xs;
        xs = signed'(x);
        return 64'(-xs);
    endfunction

endpackage

// File: rtl/posit_result_fifo.sv
// First-word-fall-through result FIFO; occupancy is exported for credit logic.
module posit_result_fifo
    import posit_ctrl_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Storage write; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/posit_addsub_scheduler.sv
// Two-requester round-robin scheduler for a shared fixed-latency posit
// add/subtract datapath, with credit-based result buffering and a drain FSM.
module posit_addsub_scheduler
    import posit_ctrl_pkg::*;
#(
    parameter int N     = 32,
    parameter int ES    = 4,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic                 dp_in_valid,
    output logic [N-1:0]         dp_a,
    output logic [N-1:0]         dp_b,
    input  logic                 dp_out_valid,
    input  logic [N-1:0]         dp_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N-1:0]         res_data,
    output logic [ID_W-1:0]      res_id,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 busy,
    output logic                 seq_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IGN_W = $clog2(LAT + 1);

    if (LAT < 1 || DEPTH < 2 || N > 64 || N < 2 || ES < 0) begin : g_param_check
        $error("posit_addsub_scheduler: unsupported parameter set");
    end

    sched_state_t     state, state_nxt;
    logic             done_sent;
    logic             rr_ptr;
    logic [CNT_W-1:0] credits;
    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             xfer;
    logic             pop;
    logic [N-1:0]     sel_a;
    logic [N-1:0]     sel_b;
    logic             sel_sub;
    logic [N-1:0]     sel_b_eff;
    logic [ID_W-1:0]  issue_id_p0;
    logic [LAT-1:0]   tag_vld_p;
    logic [ID_W-1:0]  tag_id_p [LAT];
    logic [IGN_W-1:0] ign_cnt;
    logic             ret_ok;
    logic [CNT_W-1:0] fifo_count;
    logic [ID_W+N-1:0] fifo_head;

    assign pop       = res_valid && res_ready;
    assign xfer      = |gnt;
    assign gnt_id    = gnt[1];
    assign req_ready = gnt;
    assign ret_ok    = dp_out_valid && (ign_cnt == '0);
    assign busy      = (|tag_vld_p) || (fifo_count != '0) || dp_in_valid;
    assign res_id    = fifo_head[N +: ID_W];
    assign res_data  = fifo_head[N-1:0];

    // Arbitration: round-robin between requesters, gated by credits and drain.
    always_comb begin
        gnt = '0;
        if ((state != DRAIN) && !drain_req && (credits != '0)) begin
            if (req_valid[0] && req_valid[1]) begin
                gnt[rr_ptr] = 1'b1;
            end else begin
                gnt = req_valid;
            end
        end
    end

    // Operand select for the granted requester; subtraction negates B.
    always_comb begin
        sel_a   = req_a[N-1:0];
        sel_b   = req_b[N-1:0];
        sel_sub = req_sub[0];
        if (gnt_id == 1'b1) begin
            sel_a   = req_a[2*N-1:N];
            sel_b   = req_b[2*N-1:N];
            sel_sub = req_sub[1];
        end
        sel_b_eff = sel_sub ? N'(posit_neg(64'(sel_b))) : sel_b;
    end

    // Round-robin pointer favours the side not served last.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (xfer) begin
            rr_ptr <= ~gnt_id;
        end
    end

    // Credits track free FIFO slots not already claimed by in-flight ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= CNT_W'(DEPTH);
        end else begin
            case ({xfer, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // Stage p0: issue register towards the datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_in_valid <= 1'b0;
            issue_id_p0 <= '0;
            dp_a        <= '0;
            dp_b        <= '0;
        end else begin
            dp_in_valid <= xfer;
            if (xfer) begin
                issue_id_p0 <= gnt_id;
                dp_a        <= sel_a;
                dp_b        <= sel_b_eff;
            end
        end
    end

    // Stages p1..pLAT: expected-valid shift register mirroring the datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= dp_in_valid;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
            end
        end
    end

    // Requester id travels alongside the valid bits.
    always_ff @(posedge clk) begin
        tag_id_p[0] <= issue_id_p0;
        for (int i = 1; i < LAT; i++) begin
            tag_id_p[i] <= tag_id_p[i-1];
        end
    end

    // Blind window after reset so results of discarded ops are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            ign_cnt <= IGN_W'(LAT);
        end else if (ign_cnt != '0) begin
            ign_cnt <= ign_cnt - 1'b1;
        end
    end

    // Sticky flag when returned strobes disagree with the expected pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_err <= 1'b0;
        end else if ((ign_cnt == '0) && (dp_out_valid != tag_vld_p[LAT-1])) begin
            seq_err <= 1'b1;
        end
    end

    posit_result_fifo #(
        .WIDTH (ID_W + N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (ret_ok),
        .push_data  ({tag_id_p[LAT-1], dp_result}),
        .pop        (res_ready),
        .head_valid (res_valid),
        .head_data  (fifo_head),
        .count      (fifo_count)
    );

    // FSM state register and once-per-drain pulse guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done_sent <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != DRAIN) begin
                done_sent <= 1'b0;
            end else if (drain_done) begin
                done_sent <= 1'b1;
            end
        end
    end

    // FSM next state and drain completion pulse.
    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (drain_req) begin
                    state_nxt = DRAIN;
                end else if (|req_valid) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (drain_req) begin
                    state_nxt = DRAIN;
                end else if (!busy && !(|req_valid)) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (!busy) begin
                    drain_done = !done_sent;
                    if (!drain_req) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_posit_addsub_scheduler.sv
// Scoreboard bench for posit_addsub_scheduler with a stand-in LAT-stage datapath.
module tb_posit_addsub_scheduler;

    localparam int N     = 32;
    localparam int ES    = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [1:0]     req_sub;
    logic           dp_in_valid;
    logic [N-1:0]   dp_a;
    logic [N-1:0]   dp_b;
    logic           dp_out_valid;
    logic [N-1:0]   dp_result;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [N-1:0]   res_data;
    logic           res_id;
    logic           drain_req = 1'b0;
    logic           drain_done;
    logic           busy;
    logic           seq_err;

    // Per-requester operand vectors with hand-computed dp_b and result.
    logic [N-1:0] va [2];
    logic [N-1:0] vb [2];
    logic [N-1:0] vexpb [2];
    logic [N-1:0] vres [2];
    logic         vsub [2];

    assign req_a   = {va[1], va[0]};
    assign req_b   = {vb[1], vb[0]};
    assign req_sub = {vsub[1], vsub[0]};

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int pop_cnt = 0;
    int max_out = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_pop_cyc = -1;
    logic busy_at_done = 1'b1;

    logic [63:0] iss_q [$];
    logic [32:0] res_q [$];
    int          grant_log [$];

    // Stand-in datapath: integer add, LAT cycles, plus a fault injector.
    logic         dpv [LAT];
    logic [N-1:0] dpr [LAT];
    logic         inject = 1'b0;

    initial begin
        for (int i = 0; i < LAT; i++) begin
            dpv[i] = 1'b0;
            dpr[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            va[i] = '0; vb[i] = '0; vexpb[i] = '0; vres[i] = '0; vsub[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        dpv[0] <= dp_in_valid;
        dpr[0] <= dp_a + dp_b;
        for (int i = 1; i < LAT; i++) begin
            dpv[i] <= dpv[i-1];
            dpr[i] <= dpr[i-1];
        end
    end

    assign dp_out_valid = dpv[LAT-1] | inject;
    assign dp_result    = inject ? 32'hDEAD_BEEF : dpr[LAT-1];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    posit_addsub_scheduler #(
        .N(N), .ES(ES), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sub      (req_sub),
        .dp_in_valid  (dp_in_valid),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_out_valid (dp_out_valid),
        .dp_result    (dp_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_id       (res_id),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .busy         (busy),
        .seq_err      (seq_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("idle_timeout_busy", 64'(busy), 64'(0));
    endtask

    task automatic set_vec(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic sub, input logic [N-1:0] expb, input logic [N-1:0] res);
        va[i] = a; vb[i] = b; vsub[i] = sub; vexpb[i] = expb; vres[i] = res;
    endtask

    // Records accepted transfers as expectations; tracks pops and drain pulses.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    iss_q.push_back({va[i], vexpb[i]});
                    res_q.push_back({i[0], vres[i]});
                    grant_log.push_back(i);
                    xfer_cnt++;
                end
            end
            if (res_valid && res_ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            if (drain_done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (xfer_cnt - pop_cnt > max_out) max_out = xfer_cnt - pop_cnt;
        end
    end

    // Monitor: compares issued operands and returned results against the queues.
    always @(negedge clk) begin : monitor
        logic [63:0] ie;
        logic [32:0] re;
        if (!reset && dp_in_valid) begin
            if (iss_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_issue: actual dp_a=%0h dp_b=%0h required no issue", dp_a, dp_b);
            end else begin
                ie = iss_q.pop_front();
                chk("dp_a", 64'(dp_a), 64'(ie[63:32]));
                chk("dp_b", 64'(dp_b), 64'(ie[31:0]));
            end
        end
        if (!reset && res_valid && res_ready) begin
            if (res_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_result: actual id=%0d data=%0h required no result", res_id, res_data);
            end else begin
                re = res_q.pop_front();
                chk("res_id", 64'(res_id), 64'(re[32]));
                chk("res_data", 64'(res_data), 64'(re[31:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int x0;
        bit found;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_dp_in_valid", 64'(dp_in_valid), 64'(0));
        chk("rst_dp_a", 64'(dp_a), 64'(0));
        chk("rst_dp_b", 64'(dp_b), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_data", 64'(res_data), 64'(0));
        chk("rst_res_id", 64'(res_id), 64'(0));
        chk("rst_drain_done", 64'(drain_done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_seq_err", 64'(seq_err), 64'(0));
        tick();

        // Test 1: single add from requester 0, latency LAT+2
        set_vec(0, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h8000_0000);
        res_ready = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        chk("t1_grant", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        n = 1;
        found = 1'b0;
        while (n < 20 && !found) begin
            @(negedge clk);
            if (res_valid) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk("t1_latency", 64'(n), 64'(LAT + 2));
        tick();
        wait_idle();

        // Test 2: subtraction negates B; NaR and zero map to themselves
        req_valid = 2'b10;
        set_vec(1, 32'h1000_0000, 32'h4000_0000, 1'b1, 32'hC000_0000, 32'hD000_0000);
        @(negedge clk); chk("t2_grant_a", 64'(req_ready), 64'(2'b10)); tick();
        set_vec(1, 32'h1000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 32'h9000_0000);
        @(negedge clk); chk("t2_grant_b", 64'(req_ready), 64'(2'b10)); tick();
        set_vec(1, 32'h1000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h1000_0000);
        @(negedge clk); chk("t2_grant_c", 64'(req_ready), 64'(2'b10)); tick();
        req_valid = 2'b00;
        wait_idle();

        // Test 3: both requesters valid; grants alternate starting at 0
        set_vec(0, 32'h0000_0011, 32'h0000_0022, 1'b0, 32'h0000_0022, 32'h0000_0033);
        set_vec(1, 32'h0000_0100, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF);
        grant_log.delete();
        x0 = xfer_cnt;
        n = 0;
        req_valid = 2'b11;
        while (xfer_cnt - x0 < 6 && n < 60) begin
            tick();
            n++;
        end
        req_valid = 2'b00;
        chk("t3_xfers", 64'(xfer_cnt - x0), 64'(6));
        for (int k = 0; k < 6; k++) begin
            chk("t3_grant_order", 64'((k < grant_log.size()) ? grant_log[k] : -1), 64'(k % 2));
        end
        wait_idle();

        // Test 4: consumer stalled; credits cap transfers at DEPTH
        set_vec(0, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'hFFFF_FFFD, 32'h0000_0002);
        res_ready = 1'b0;
        max_out = 0;
        x0 = xfer_cnt;
        req_valid = 2'b01;
        repeat (12) tick();
        @(negedge clk);
        chk("t4_xfers_full", 64'(xfer_cnt - x0), 64'(DEPTH));
        chk("t4_ready_full", 64'(req_ready), 64'(0));
        chk("t4_res_valid", 64'(res_valid), 64'(1));
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        chk("t4_no_grant_on_pop", 64'(req_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("t4_grant_after_pop", 64'(req_ready), 64'(2'b01));
        repeat (6) tick();
        req_valid = 2'b00;
        wait_idle();
        chk("t4_max_outstanding", 64'(max_out), 64'(DEPTH));
        chk("t4_balance", 64'(pop_cnt), 64'(xfer_cnt));

        // Test 5: drain with three ops in flight
        set_vec(0, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0001, 32'h0000_0002);
        res_ready = 1'b1;
        req_valid = 2'b01;
        repeat (3) tick();
        drain_req = 1'b1;
        done_cnt = 0;
        x0 = xfer_cnt;
        @(negedge clk);
        chk("t5_ready_blocked", 64'(req_ready), 64'(0));
        chk("t5_busy_inflight", 64'(busy), 64'(1));
        repeat (20) tick();
        @(negedge clk);
        chk("t5_no_grants", 64'(xfer_cnt - x0), 64'(0));
        chk("t5_done_pulses", 64'(done_cnt), 64'(1));
        chk("t5_done_after_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
        chk("t5_busy_at_done", 64'(busy_at_done), 64'(0));
        chk("t5_busy_end", 64'(busy), 64'(0));
        chk("t5_ready_held", 64'(req_ready), 64'(0));
        tick();
        drain_req = 1'b0;
        req_valid = 2'b00;
        repeat (2) tick();

        // Test 6: reset mid-stream, stale returns ignored, then spurious strobe
        set_vec(0, 32'h0000_0002, 32'h0000_0002, 1'b0, 32'h0000_0002, 32'h0000_0004);
        res_ready = 1'b1;
        req_valid = 2'b01;
        repeat (2) tick();
        reset = 1'b1;
        req_valid = 2'b00;
        tick();
        iss_q.delete();
        res_q.delete();
        xfer_cnt = 0;
        pop_cnt = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_res_valid", 64'(res_valid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_seq_err", 64'(seq_err), 64'(0));
        chk("t6_rst_dp_in_valid", 64'(dp_in_valid), 64'(0));
        repeat (LAT + 2) tick();
        @(negedge clk);
        chk("t6_stale_seq_err", 64'(seq_err), 64'(0));
        chk("t6_stale_res_valid", 64'(res_valid), 64'(0));
        tick();
        res_ready = 1'b0;
        x0 = xfer_cnt;
        req_valid = 2'b01;
        repeat (10) tick();
        @(negedge clk);
        chk("t6_credits_after_reset", 64'(xfer_cnt - x0), 64'(DEPTH));
        chk("t6_ready_full", 64'(req_ready), 64'(0));
        tick();
        req_valid = 2'b00;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        chk("t6_spurious_seq_err", 64'(seq_err), 64'(1));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
